// File: rtl/bram2_adc_capture_ctrl.sv
// Dual-channel ADC capture controller writing pre/post-trigger windows into a pair of BRAMs.
// Optional level-crossing trigger on channel A is compiled in when TRIG_LEVEL_EN is defined.
module bram2_adc_capture_ctrl #(
   parameter int unsigned ADDR_W = 14,
   parameter int unsigned DATA_W = 14
) (
   input  logic              ACLK,
   input  logic              ARESET,
   input  logic [DATA_W-1:0] adc_a_i,
   input  logic [DATA_W-1:0] adc_b_i,
   input  logic              adc_valid_i,
   input  logic              arm_i,
   input  logic              abort_i,
   input  logic              sw_trig_i,
   input  logic              ext_trig_i,
   input  logic [1:0]        trig_src_i,
   input  logic [DATA_W-1:0] trig_level_i,
   input  logic [ADDR_W-1:0] pre_len_i,
   input  logic [ADDR_W-1:0] post_len_i,
   output logic              bram_we_o,
   output logic [ADDR_W-1:0] bram_addr_o,
   output logic [DATA_W-1:0] bram_dina_o,
   output logic [DATA_W-1:0] bram_dinb_o,
   output logic              busy_o,
   output logic              armed_o,
   output logic              done_o,
   output logic [ADDR_W-1:0] trig_addr_o,
   output logic              wrapped_o
);

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_PRE  = 3'd1;
   localparam logic [2:0] ST_WAIT = 3'd2;
   localparam logic [2:0] ST_POST = 3'd3;
   localparam logic [2:0] ST_DONE = 3'd4;

   localparam logic [1:0] SRC_SW  = 2'd0;
   localparam logic [1:0] SRC_EXT = 2'd1;

   localparam logic [ADDR_W-1:0] PTR_MAX = '1;
   localparam logic [ADDR_W-1:0] ONE     = ADDR_W'(1);

   logic [2:0]        state_q, state_d;
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic [ADDR_W-1:0] post_q, post_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;
   logic [DATA_W-1:0] dina_q, dina_d;
   logic [DATA_W-1:0] dinb_q, dinb_d;
   logic [1:0]        src_q, src_d;
   logic              we_q, we_d;
   logic              done_q, done_d;
   logic              wrapped_q, wrapped_d;
   logic              pend_q, pend_d;
   logic              ext_prev_q, ext_prev_d;
   logic              busy_q, busy_d;
   logic              armed_q, armed_d;

   logic run, waiting, sample, ev, lvl_hit, fire;

`ifdef TRIG_LEVEL_EN
   localparam logic [1:0] SRC_LVL = 2'd2;
   logic [DATA_W-1:0] level_q, level_d;
   logic [DATA_W-1:0] prev_a_q, prev_a_d;
   logic              prev_ok_q, prev_ok_d;
`else
   logic unused_level;
   assign unused_level = ^trig_level_i;
`endif

   // Next-state, datapath and status computation
   always_comb begin
      state_d     = state_q;
      wr_ptr_d    = wr_ptr_q;
      cnt_d       = cnt_q;
      post_d      = post_q;
      addr_d      = addr_q;
      trig_addr_d = trig_addr_q;
      dina_d      = dina_q;
      dinb_d      = dinb_q;
      src_d       = src_q;
      we_d        = 1'b0;
      done_d      = done_q;
      wrapped_d   = wrapped_q;
      pend_d      = pend_q;
      ext_prev_d  = ext_trig_i;
      run         = (state_q == ST_PRE) || (state_q == ST_WAIT) || (state_q == ST_POST);
      waiting     = (state_q == ST_WAIT);
      sample      = run && adc_valid_i;
      ev          = waiting && (((src_q == SRC_SW) && sw_trig_i) ||
                                ((src_q == SRC_EXT) && ext_trig_i && !ext_prev_q));
      lvl_hit     = 1'b0;
`ifdef TRIG_LEVEL_EN
      level_d     = level_q;
      prev_a_d    = prev_a_q;
      prev_ok_d   = prev_ok_q;
      lvl_hit     = waiting && (src_q == SRC_LVL) && prev_ok_q &&
                    ($signed(prev_a_q) < $signed(level_q)) &&
                    ($signed(level_q) <= $signed(adc_a_i));
`endif
      fire        = sample && waiting && (pend_q || ev || lvl_hit);

      if (abort_i) begin
         state_d = ST_IDLE;
         done_d  = 1'b0;
         pend_d  = 1'b0;
      end else if (!run) begin
         if (arm_i) begin
            src_d     = trig_src_i;
            post_d    = (post_len_i == '0) ? ONE : post_len_i;
            cnt_d     = pre_len_i;
            wr_ptr_d  = '0;
            done_d    = 1'b0;
            wrapped_d = 1'b0;
            pend_d    = 1'b0;
            state_d   = (pre_len_i == '0) ? ST_WAIT : ST_PRE;
`ifdef TRIG_LEVEL_EN
            level_d   = trig_level_i;
            prev_ok_d = 1'b0;
`endif
         end else if (state_q == ST_DONE) begin
            done_d = 1'b1;
         end
      end else if (sample) begin
         we_d     = 1'b1;
         addr_d   = wr_ptr_q;
         dina_d   = adc_a_i;
         dinb_d   = adc_b_i;
         wr_ptr_d = wr_ptr_q + ONE;
         if (wr_ptr_q == PTR_MAX) wrapped_d = 1'b1;
`ifdef TRIG_LEVEL_EN
         prev_a_d  = adc_a_i;
         prev_ok_d = 1'b1;
`endif
         case (state_q)
            ST_PRE: begin
               if (cnt_q == ONE) state_d = ST_WAIT;
               else              cnt_d   = cnt_q - ONE;
            end
            ST_WAIT: begin
               // The trigger sample itself is the first post-trigger sample
               if (fire) begin
                  trig_addr_d = wr_ptr_q;
                  pend_d      = 1'b0;
                  if (post_q == ONE) begin
                     state_d = ST_DONE;
                  end else begin
                     state_d = ST_POST;
                     cnt_d   = post_q - ONE;
                  end
               end
            end
            ST_POST: begin
               if (cnt_q == ONE) state_d = ST_DONE;
               else              cnt_d   = cnt_q - ONE;
            end
            default: ;
         endcase
      end else if (ev) begin
         pend_d = 1'b1;
      end

      busy_d  = (state_d == ST_PRE) || (state_d == ST_WAIT) || (state_d == ST_POST);
      armed_d = (state_d == ST_WAIT);
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state_q     <= ST_IDLE;
         wr_ptr_q    <= '0;
         cnt_q       <= '0;
         post_q      <= '0;
         addr_q      <= '0;
         trig_addr_q <= '0;
         dina_q      <= '0;
         dinb_q      <= '0;
         src_q       <= '0;
         we_q        <= 1'b0;
         done_q      <= 1'b0;
         wrapped_q   <= 1'b0;
         pend_q      <= 1'b0;
         ext_prev_q  <= 1'b0;
         busy_q      <= 1'b0;
         armed_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         cnt_q       <= cnt_d;
         post_q      <= post_d;
         addr_q      <= addr_d;
         trig_addr_q <= trig_addr_d;
         dina_q      <= dina_d;
         dinb_q      <= dinb_d;
         src_q       <= src_d;
         we_q        <= we_d;
         done_q      <= done_d;
         wrapped_q   <= wrapped_d;
         pend_q      <= pend_d;
         ext_prev_q  <= ext_prev_d;
         busy_q      <= busy_d;
         armed_q     <= armed_d;
      end
   end

`ifdef TRIG_LEVEL_EN
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         level_q   <= '0;
         prev_a_q  <= '0;
         prev_ok_q <= 1'b0;
      end else begin
         level_q   <= level_d;
         prev_a_q  <= prev_a_d;
         prev_ok_q <= prev_ok_d;
      end
   end
`endif

   assign bram_we_o   = we_q;
   assign bram_addr_o = addr_q;
   assign bram_dina_o = dina_q;
   assign bram_dinb_o = dinb_q;
   assign busy_o      = busy_q;
   assign armed_o     = armed_q;
   assign done_o      = done_q;
   assign trig_addr_o = trig_addr_q;
   assign wrapped_o   = wrapped_q;

endmodule
